// File: rtl/and_vector_driver.sv
// -----------------------------------------------------------------------------
// and_vector_driver
//
// Stimulus and check stage for a zero-latency AND block (out = a & b).
// On start the block walks every (a,b) operand pair in order. Each pair is held
// for HOLD cycles. On the last hold cycle the block compares dut_out against
// a & b. It counts mismatches into a saturating counter and reports pass/fail
// at the end of the sweep.
//
// Parameters
//   WIDTH  operand width of a, b, dut_out
//   HOLD   cycles each vector is held (>= 1)
//   ERRW   width of err_cnt; the counter saturates at all-ones
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   start      in   begin a sweep; only honoured in IDLE
//   dut_out    in   output of the AND block under test
//   a, b       out  registered operands, {a,b} == vec_idx
//   vec_valid  out  a/b carry a live vector (DRIVE)
//   vec_idx    out  index of the current vector
//   busy       out  sweep in progress (DRIVE)
//   done       out  one-cycle pulse at end of sweep
//   pass       out  last sweep had zero mismatches; held until next start
//   err_cnt    out  mismatch count of current/last sweep
// -----------------------------------------------------------------------------
module and_vector_driver #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned HOLD  = 1,
  parameter int unsigned ERRW  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dut_out,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 vec_valid,
  output logic [2*WIDTH-1:0]   vec_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERRW-1:0]      err_cnt
);

  localparam int unsigned VW = 2 * WIDTH;
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [VW-1:0] IDX_LAST  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [HW-1:0]   hold_cnt;
  logic            last_hold;
  logic            last_vec;
  logic            mismatch;
  logic [ERRW-1:0] err_upd;

  // The operands are the two halves of the registered vector index, so a/b
  // are registered and the sweep order is {a,b} = 0 .. 2**(2W)-1.
  assign a = vec_idx[VW-1:WIDTH];
  assign b = vec_idx[WIDTH-1:0];

  assign last_hold = (hold_cnt == HOLD_LAST);
  assign last_vec  = (vec_idx == IDX_LAST);
  assign mismatch  = (dut_out != (a & b));

  // The error count after this cycle's compare. It saturates at all-ones.
  // The pass decision uses this value, so that the final vector's compare
  // is included.
  always_comb begin
    err_upd = err_cnt;
    if (mismatch && (err_cnt != '1)) begin
      err_upd = err_cnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRIVE;
      S_DRIVE: if (last_hold && last_vec) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    vec_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_DRIVE: begin
        vec_valid = 1'b1;
        busy      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Sweep datapath: vector index, hold counter, error counter, pass flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx  <= '0;
      hold_cnt <= '0;
      err_cnt  <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_idx  <= '0;
            hold_cnt <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (last_hold) begin
            err_cnt <= err_upd;
            if (last_vec) begin
              // The index stays on the last vector through DONE.
              pass <= (err_upd == '0);
            end else begin
              vec_idx  <= vec_idx + 1'b1;
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_and_vector_driver.sv
// -----------------------------------------------------------------------------
// tb_and_vector_driver
//
// Directed bench for and_vector_driver. Four instances are used:
//   u0  WIDTH=1 HOLD=1 ERRW=4, AND block selectable as AND / OR / NAND
//   u1  WIDTH=1 HOLD=3 ERRW=4, true AND
//   u2  WIDTH=1 HOLD=1 ERRW=1, NAND (saturation)
//   u3  WIDTH=2 HOLD=1 ERRW=4, true AND
// -----------------------------------------------------------------------------
module tb_and_vector_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;

  // u0
  logic       st0;
  logic [0:0] out0, a0, b0;
  logic       vv0, busy0, done0, pass0;
  logic [1:0] idx0;
  logic [3:0] err0;
  int         mode0 = 0;

  // u1
  logic       st1;
  logic [0:0] out1, a1, b1;
  logic       vv1, busy1, done1, pass1;
  logic [1:0] idx1;
  logic [3:0] err1;

  // u2
  logic       st2;
  logic [0:0] out2, a2, b2;
  logic       vv2, busy2, done2, pass2;
  logic [1:0] idx2;
  logic [0:0] err2;

  // u3
  logic       st3;
  logic [1:0] out3, a3, b3;
  logic       vv3, busy3, done3, pass3;
  logic [3:0] idx3;
  logic [3:0] err3;

  always_comb begin
    case (mode0)
      1:       out0 = a0 | b0;
      2:       out0 = ~(a0 & b0);
      default: out0 = a0 & b0;
    endcase
  end
  assign out1 = a1 & b1;
  assign out2 = ~(a2 & b2);
  assign out3 = a3 & b3;

  and_vector_driver #(.WIDTH(1), .HOLD(1), .ERRW(4)) u0 (
    .clk(clk), .rst(rst), .start(st0), .dut_out(out0), .a(a0), .b(b0),
    .vec_valid(vv0), .vec_idx(idx0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err0));

  and_vector_driver #(.WIDTH(1), .HOLD(3), .ERRW(4)) u1 (
    .clk(clk), .rst(rst), .start(st1), .dut_out(out1), .a(a1), .b(b1),
    .vec_valid(vv1), .vec_idx(idx1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1));

  and_vector_driver #(.WIDTH(1), .HOLD(1), .ERRW(1)) u2 (
    .clk(clk), .rst(rst), .start(st2), .dut_out(out2), .a(a2), .b(b2),
    .vec_valid(vv2), .vec_idx(idx2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err2));

  and_vector_driver #(.WIDTH(2), .HOLD(1), .ERRW(4)) u3 (
    .clk(clk), .rst(rst), .start(st3), .dut_out(out3), .a(a3), .b(b3),
    .vec_valid(vv3), .vec_idx(idx3), .busy(busy3), .done(done3),
    .pass(pass3), .err_cnt(err3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // The bench model of the AND block under test, as selected by mode.
  function automatic int model_out(input int mode, input int x, input int y);
    case (mode)
      1:       return x | y;
      2:       return (~(x & y)) & 1;
      default: return x & y;
    endcase
  endfunction

  // One full sweep on u0. If repulse is set, start is pulsed while vector 1 is live.
  task automatic sweep0(input int mode, input bit repulse);
    int ne;
    int av;
    int bv;
    mode0 = mode;
    ne    = 0;
    st0   = 1'b1;
    tick();
    st0   = 1'b0;
    for (int v = 0; v < 4; v++) begin
      av = (v >> 1) & 1;
      bv = v & 1;
      chk("u0_a",     a0,    av);
      chk("u0_b",     b0,    bv);
      chk("u0_idx",   idx0,  v);
      chk("u0_valid", vv0,   1);
      chk("u0_busy",  busy0, 1);
      chk("u0_done",  done0, 0);
      chk("u0_err",   err0,  ne);
      if (model_out(mode, av, bv) != (av & bv)) ne++;
      st0 = (repulse && v == 1);
      tick();
    end
    st0 = 1'b0;
    chk("u0_done_hi", done0, 1);
    chk("u0_busy_lo", busy0, 0);
    chk("u0_vld_lo",  vv0,   0);
    chk("u0_err_end", err0,  ne);
    chk("u0_pass",    pass0, (ne == 0));
    chk("u0_hold_ab", {a0, b0}, 3);
    tick();
    chk("u0_done_1cy", done0, 0);
    chk("u0_idle",     busy0, 0);
    chk("u0_pass_hld", pass0, (ne == 0));
    chk("u0_err_hld",  err0,  ne);
    tick();
    chk("u0_no_2nd",   done0, 0);
    chk("u0_idle2",    busy0, 0);
  endtask

  initial begin
    int ne;
    rst = 1'b1;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_a",    a0,    0);
    chk("rst_b",    b0,    0);
    chk("rst_idx",  idx0,  0);
    chk("rst_vld",  vv0,   0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err",  err0,  0);
    rst = 1'b0;
    tick();

    // T1 true AND, T2 OR (2 mismatches), T4 start re-pulsed mid-sweep
    sweep0(0, 1'b0);
    sweep0(1, 1'b0);
    sweep0(0, 1'b1);

    // T3 HOLD=3: each vector for 3 cycles, done in the 13th cycle
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("u1_valid", vv1,  1);
      chk("u1_idx",   idx1, c / 3);
      chk("u1_ab",    {a1, b1}, c / 3);
      chk("u1_done",  done1, 0);
      tick();
    end
    chk("u1_done_hi", done1, 1);
    chk("u1_vld_lo",  vv1,   0);
    chk("u1_busy_lo", busy1, 0);
    chk("u1_pass",    pass1, 1);
    chk("u1_err",     err1,  0);

    // T6a ERRW=1 with NAND: the error count saturates at 1
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    ne = 0;
    for (int v = 0; v < 4; v++) begin
      chk("u2_idx",  idx2,  v);
      chk("u2_ab",   {a2, b2}, v);
      chk("u2_busy", busy2, 1);
      chk("u2_vld",  vv2,   1);
      chk("u2_err",  err2,  ne);
      if (ne < 1) ne++;
      tick();
    end
    chk("u2_done_hi", done2, 1);
    chk("u2_err_sat", err2,  1);
    chk("u2_pass",    pass2, 0);

    // T6b WIDTH=2 true AND: 16 vectors, pass
    st3 = 1'b1;
    tick();
    st3 = 1'b0;
    for (int v = 0; v < 16; v++) begin
      chk("u3_a",    a3,    v >> 2);
      chk("u3_b",    b3,    v & 3);
      chk("u3_idx",  idx3,  v);
      chk("u3_vld",  vv3,   1);
      chk("u3_busy", busy3, 1);
      chk("u3_done", done3, 0);
      tick();
    end
    chk("u3_done_hi", done3, 1);
    chk("u3_pass",    pass3, 1);
    chk("u3_err",     err3,  0);
    tick();

    // T5 reset asserted at vec_idx=2 clears everything at once; no done pulse follows
    mode0 = 0;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    tick();
    tick();
    chk("t5_idx2", idx0, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_a",    a0,    0);
    chk("t5_b",    b0,    0);
    chk("t5_idx",  idx0,  0);
    chk("t5_vld",  vv0,   0);
    chk("t5_busy", busy0, 0);
    chk("t5_done", done0, 0);
    chk("t5_pass", pass0, 0);
    chk("t5_err",  err0,  0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t5_nodone", done0, 0);
      chk("t5_nobusy", busy0, 0);
      tick();
    end
    sweep0(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
